// File: rtl/tdc_frame_sequencer.sv
// tdc_frame_sequencer
// Captures a DATASIZE-bit TDC snapshot on each accepted sample tick and sends it to uart_tx
// as one framed packet: SYNC, SEQ, data bytes LSB-first, then the XOR of SEQ and the data bytes.
// A watchdog drops a frame whose byte is not acknowledged within TIMEOUT_CYC cycles.
// Ticks that arrive while a frame is in progress are dropped and counted.
//
// Ports
//   clk10m       system clock, posedge
//   rst_n        asynchronous reset, active-low
//   sample_tick  one-cycle capture/send request (accepted only when idle)
//   sample_data  snapshot, sampled in the tick-accept cycle only
//   tx_push      one-cycle byte strobe to uart_tx
//   tx_byte      byte to send, held from one push until the next
//   tx_done      uart_tx byte-complete pulse
//   busy         frame in progress
//   frame_done   one-cycle pulse: checksum byte acknowledged
//   frame_abort  one-cycle pulse: watchdog expired, frame dropped
//   seq_num      sequence number of the next frame
//   overrun_cnt  saturating count of dropped ticks
module tdc_frame_sequencer #(
  parameter int unsigned DATASIZE    = 128,
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
  parameter int unsigned TIMEOUT_CYC = 2048
) (
  input  logic                clk10m,
  input  logic                rst_n,
  input  logic                sample_tick,
  input  logic [DATASIZE-1:0] sample_data,
  output logic                tx_push,
  output logic [7:0]          tx_byte,
  input  logic                tx_done,
  output logic                busy,
  output logic                frame_done,
  output logic                frame_abort,
  output logic [7:0]          seq_num,
  output logic [7:0]          overrun_cnt
);

  localparam int unsigned NBytes  = DATASIZE / 8;
  localparam int unsigned LastIdx = NBytes + 2;
  localparam int unsigned IdxW    = $clog2(LastIdx + 1);
  localparam int unsigned WdogW   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [1:0] {StIdle, StSend, StWait} state_e;

  state_e              state_q;
  logic [DATASIZE-1:0] shadow_q;
  logic [IdxW-1:0]     idx_q;
  logic [7:0]          csum_q;
  logic [WdogW-1:0]    wdog_q;
  logic                tx_push_q;
  logic [7:0]          tx_byte_q;
  logic                busy_q;
  logic [7:0]          seq_q;
  logic [7:0]          ovr_q;

  logic [IdxW-1:0] idx_nxt;
  logic [IdxW-1:0] data_k;
  logic [7:0]      next_byte;
  logic            is_last;
  logic            wdog_exp;

  assign idx_nxt  = idx_q + IdxW'(1);
  assign data_k   = idx_nxt - IdxW'(2);
  assign is_last  = (idx_q == IdxW'(LastIdx));
  assign wdog_exp = (wdog_q == WdogW'(TIMEOUT_CYC - 1));

  // Byte for the slot after the current one; byte(0) is loaded straight from SYNC_BYTE.
  // csum_q already covers byte(idx_q) here, so it is complete when the checksum slot is next.
  always_comb begin
    next_byte = 8'h00;
    if (idx_nxt == IdxW'(1)) begin
      next_byte = seq_q;
    end else if (idx_nxt == IdxW'(LastIdx)) begin
      next_byte = csum_q;
    end else begin
      next_byte = 8'(shadow_q >> {data_k, 3'b000});
    end
  end

  // End-of-frame pulses coincide with the last WAIT cycle, so a tick in that cycle is dropped.
  assign frame_done  = (state_q == StWait) && tx_done && is_last;
  assign frame_abort = (state_q == StWait) && !tx_done && wdog_exp;

  always_ff @(posedge clk10m or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      shadow_q  <= '0;
      idx_q     <= '0;
      csum_q    <= 8'h00;
      wdog_q    <= '0;
      tx_push_q <= 1'b0;
      tx_byte_q <= 8'h00;
      busy_q    <= 1'b0;
      seq_q     <= 8'h00;
      ovr_q     <= 8'h00;
    end else begin
      tx_push_q <= 1'b0;
      if (sample_tick && (state_q != StIdle) && (ovr_q != 8'hFF)) begin
        ovr_q <= ovr_q + 8'd1;
      end
      case (state_q)
        StIdle: begin
          if (sample_tick) begin
            shadow_q  <= sample_data;
            idx_q     <= '0;
            csum_q    <= 8'h00;
            tx_byte_q <= SYNC_BYTE;
            tx_push_q <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= StSend;
          end
        end
        StSend: begin
          // SYNC and the checksum itself are excluded from the checksum.
          if ((idx_q != '0) && !is_last) begin
            csum_q <= csum_q ^ tx_byte_q;
          end
          wdog_q  <= '0;
          state_q <= StWait;
        end
        StWait: begin
          if (tx_done) begin
            if (is_last) begin
              seq_q   <= seq_q + 8'd1;
              busy_q  <= 1'b0;
              state_q <= StIdle;
            end else begin
              idx_q     <= idx_nxt;
              tx_byte_q <= next_byte;
              tx_push_q <= 1'b1;
              state_q   <= StSend;
            end
          end else if (wdog_exp) begin
            seq_q   <= seq_q + 8'd1;
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end else begin
            wdog_q <= wdog_q + WdogW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign tx_push     = tx_push_q;
  assign tx_byte     = tx_byte_q;
  assign busy        = busy_q;
  assign seq_num     = seq_q;
  assign overrun_cnt = ovr_q;

endmodule

// File: tb/tb_tdc_frame_sequencer.sv
module tb_tdc_frame_sequencer;

  localparam int unsigned DW = 16;
  localparam int unsigned TO = 16;

  logic          clk10m = 1'b0;
  logic          rst_n;
  logic          sample_tick;
  logic [DW-1:0] sample_data;
  logic          tx_push;
  logic [7:0]    tx_byte;
  logic          tx_done;
  logic          busy;
  logic          frame_done;
  logic          frame_abort;
  logic [7:0]    seq_num;
  logic [7:0]    overrun_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Monitor / responder state
  int         cyc = 0;
  logic [7:0] bytes[$];
  int         done_cnt, abort_cnt, push_wide, push_cyc, abort_cyc;
  logic       prev_push;
  bit         resp_en;
  int         resp_delay = 10;
  int         resp_cnt = -1;
  logic       tx_done_nxt;

  tdc_frame_sequencer #(
    .DATASIZE   (DW),
    .SYNC_BYTE  (8'hA5),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk10m     (clk10m),
    .rst_n      (rst_n),
    .sample_tick(sample_tick),
    .sample_data(sample_data),
    .tx_push    (tx_push),
    .tx_byte    (tx_byte),
    .tx_done    (tx_done),
    .busy       (busy),
    .frame_done (frame_done),
    .frame_abort(frame_abort),
    .seq_num    (seq_num),
    .overrun_cnt(overrun_cnt)
  );

  always #5 clk10m = ~clk10m;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  // One clock: observe at negedge, then update tx_done just after the posedge.
  task automatic cycle();
    @(negedge clk10m);
    tx_done_nxt = 1'b0;
    if (tx_push) begin
      bytes.push_back(tx_byte);
      if (prev_push) push_wide++;
      if (push_cyc < 0) push_cyc = cyc;
    end
    prev_push = tx_push;
    if (frame_done) done_cnt++;
    if (frame_abort) begin
      abort_cnt++;
      abort_cyc = cyc;
    end
    if (tx_push && resp_en) resp_cnt = resp_delay;
    else if (resp_cnt > 1) resp_cnt--;
    else if (resp_cnt == 1) begin
      resp_cnt    = -1;
      tx_done_nxt = 1'b1;
    end
    @(posedge clk10m);
    #1;
    tx_done = tx_done_nxt;
    cyc++;
  endtask

  task automatic clear_mon();
    bytes.delete();
    done_cnt  = 0;
    abort_cnt = 0;
    push_wide = 0;
    push_cyc  = -1;
    abort_cyc = -1;
    prev_push = 1'b0;
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    sample_tick = 1'b0;
    sample_data = '0;
    tx_done     = 1'b0;
    resp_en     = 1'b1;
    resp_cnt    = -1;
    repeat (2) @(posedge clk10m);
    #1;
    rst_n = 1'b1;
    clear_mon();
  endtask

  task automatic send_tick(input logic [DW-1:0] d);
    sample_data = d;
    sample_tick = 1'b1;
    cycle();
    sample_tick = 1'b0;
  endtask

  task automatic wait_frame_end(input int budget);
    int start;
    int n;
    start = done_cnt + abort_cnt;
    n = 0;
    while ((done_cnt + abort_cnt == start) && (n < budget)) begin
      cycle();
      n++;
    end
    n_checks++;
    if (done_cnt + abort_cnt == start) begin
      n_fail++;
      $display("FAIL frame_end_wait: no frame_done/frame_abort within %0d cycles", budget);
    end
  endtask

  // exp holds the five bytes, first byte in bits [39:32].
  task automatic check_bytes(input string name, input logic [39:0] exp);
    n_checks++;
    if (bytes.size() != 5) begin
      n_fail++;
      $display("FAIL %s_len: got %0d bytes, expected 5", name, bytes.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_checks++;
        if (bytes[i] !== exp[8*(4-i) +: 8]) begin
          n_fail++;
          $display("FAIL %s_byte%0d: got %02h, expected %02h", name, i, bytes[i],
                   exp[8*(4-i) +: 8]);
        end
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({tx_push, busy, frame_done, frame_abort, tx_byte, seq_num, overrun_cnt} !== 28'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: push=%b busy=%b done=%b abort=%b byte=%02h seq=%02h ovr=%02h, expected all 0",
               tx_push, busy, frame_done, frame_abort, tx_byte, seq_num, overrun_cnt);
    end
  endtask

  task automatic test_single_frame();
    send_tick(16'h3C5A);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL frame1_busy: got %b, expected 1", busy);
    end
    wait_frame_end(200);
    check_bytes("frame1", 40'hA5_00_5A_3C_66);
    n_checks++;
    if (done_cnt !== 1) begin
      n_fail++;
      $display("FAIL frame1_done_cnt: got %0d, expected 1", done_cnt);
    end
    n_checks++;
    if (seq_num !== 8'd1) begin
      n_fail++;
      $display("FAIL frame1_seq: got %02h, expected 01", seq_num);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL frame1_busy_end: got %b, expected 0", busy);
    end
  endtask

  task automatic test_back_to_back();
    clear_mon();
    send_tick(16'hFFFF);
    wait_frame_end(200);
    check_bytes("frame2", 40'hA5_01_FF_FF_01);
    n_checks++;
    if (seq_num !== 8'd2) begin
      n_fail++;
      $display("FAIL frame2_seq: got %02h, expected 02", seq_num);
    end
    n_checks++;
    if (push_wide !== 0) begin
      n_fail++;
      $display("FAIL push_width: got %0d multi-cycle pushes, expected 0", push_wide);
    end
  endtask

  task automatic test_overrun();
    do_reset();
    send_tick(16'h1234);
    repeat (3) cycle();
    for (int i = 0; i < 3; i++) begin
      sample_data = DW'($urandom);
      sample_tick = 1'b1;
      cycle();
      sample_tick = 1'b0;
      cycle();
    end
    wait_frame_end(200);
    check_bytes("overrun_frame", 40'hA5_00_34_12_26);
    n_checks++;
    if (overrun_cnt !== 8'd3) begin
      n_fail++;
      $display("FAIL overrun_three: got %02h, expected 03", overrun_cnt);
    end
    sample_tick = 1'b1;
    repeat (400) cycle();
    sample_tick = 1'b0;
    n_checks++;
    if (overrun_cnt !== 8'hFF) begin
      n_fail++;
      $display("FAIL overrun_saturate: got %02h, expected ff", overrun_cnt);
    end
    sample_tick = 1'b1;
    repeat (40) cycle();
    sample_tick = 1'b0;
    n_checks++;
    if (overrun_cnt !== 8'hFF) begin
      n_fail++;
      $display("FAIL overrun_hold: got %02h, expected ff", overrun_cnt);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    resp_en = 1'b0;
    send_tick(16'hBEEF);
    wait_frame_end(100);
    n_checks++;
    if (abort_cnt !== 1 || done_cnt !== 0) begin
      n_fail++;
      $display("FAIL timeout_pulses: abort=%0d done=%0d, expected 1 and 0", abort_cnt, done_cnt);
    end
    n_checks++;
    if (abort_cyc - push_cyc !== 16) begin
      n_fail++;
      $display("FAIL timeout_latency: got %0d cycles, expected 16", abort_cyc - push_cyc);
    end
    n_checks++;
    if (busy !== 1'b0 || seq_num !== 8'd1) begin
      n_fail++;
      $display("FAIL timeout_state: busy=%b seq=%02h, expected 0 and 01", busy, seq_num);
    end
    n_checks++;
    if (bytes.size() !== 1) begin
      n_fail++;
      $display("FAIL timeout_pushes: got %0d, expected 1", bytes.size());
    end
    resp_en = 1'b1;
    clear_mon();
    send_tick(16'h0102);
    wait_frame_end(200);
    check_bytes("after_abort", 40'hA5_01_02_01_02);
  endtask

  task automatic test_tick_on_done();
    bit hit;
    do_reset();
    send_tick(16'h00FF);
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      cycle();
      if (tx_done && bytes.size() == 5) hit = 1'b1;
    end
    n_checks++;
    if (!hit) begin
      n_fail++;
      $display("FAIL done_cycle_reach: last tx_done not reached, got 0 expected 1");
    end
    sample_tick = 1'b1;
    cycle();
    sample_tick = 1'b0;
    n_checks++;
    if (done_cnt !== 1 || overrun_cnt !== 8'd1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL tick_on_done: done=%0d ovr=%02h busy=%b, expected 1 01 0",
               done_cnt, overrun_cnt, busy);
    end
    clear_mon();
    send_tick(16'hA55A);
    n_checks++;
    if (busy !== 1'b1 || overrun_cnt !== 8'd1) begin
      n_fail++;
      $display("FAIL tick_after_done: busy=%b ovr=%02h, expected 1 01", busy, overrun_cnt);
    end
    wait_frame_end(200);
    check_bytes("after_done", 40'hA5_01_5A_A5_FE);
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    send_tick(16'h7788);
    for (int i = 0; i < 200 && bytes.size() < 2; i++) cycle();
    #1;
    rst_n    = 1'b0;
    tx_done  = 1'b0;
    resp_cnt = -1;
    #1;
    n_checks++;
    if ({tx_push, busy, frame_done, frame_abort, tx_byte, seq_num, overrun_cnt} !== 28'h0) begin
      n_fail++;
      $display("FAIL async_reset: push=%b busy=%b done=%b abort=%b byte=%02h seq=%02h ovr=%02h, expected all 0",
               tx_push, busy, frame_done, frame_abort, tx_byte, seq_num, overrun_cnt);
    end
    @(posedge clk10m);
    #1;
    rst_n = 1'b1;
    clear_mon();
    repeat (3) cycle();
    n_checks++;
    if (done_cnt + abort_cnt + bytes.size() !== 0) begin
      n_fail++;
      $display("FAIL stale_pulses: got %0d events, expected 0",
               done_cnt + abort_cnt + bytes.size());
    end
    send_tick(16'h1111);
    wait_frame_end(200);
    check_bytes("after_reset", 40'hA5_00_11_11_00);
    n_checks++;
    if (abort_cnt !== 0) begin
      n_fail++;
      $display("FAIL after_reset_abort: got %0d, expected 0", abort_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_overrun();
    test_timeout();
    test_tick_on_done();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
